// File: rtl/tpu_host_driver.sv
// rtl/tpu_host_driver.sv - host-side serialiser/deserialiser for the 2x2 systolic TPU pin interface
// Optional WAIT_DONE timeout is enabled by defining TPU_HOST_TIMEOUT_EN.
module tpu_host_driver #(
  parameter int RESULT_BYTES = 8
`ifdef TPU_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               mat_a,
  input  logic [31:0]               mat_b,
  input  logic                      transpose_cfg,
  input  logic                      relu_cfg,
  output logic                      busy,
  output logic [8*RESULT_BYTES-1:0] result,
  output logic                      result_valid,
  output logic                      error,
  output logic [7:0]                tpu_ui_in,
  output logic [7:0]                tpu_uio_in,
  input  logic [7:0]                tpu_uo_out,
  input  logic [7:0]                tpu_uio_out
);

  localparam int IW = $clog2((RESULT_BYTES > 8) ? RESULT_BYTES : 8);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, READ, FINISH} state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             idx;
  logic [63:0]               ops;
  logic                      tr_q, relu_q;
  logic [8*RESULT_BYTES-1:0] shadow;
  logic [7:0]                ui_nx, uio_nx;
  logic [63:0]               src;
  logic [2:0]                lidx;
  logic                      tr_nx, relu_nx, go;
  logic                      done;
  logic                      timed_out;
  logic                      unused_uio;

  assign done       = tpu_uio_out[7];
  assign unused_uio = ^tpu_uio_out[6:0];

`ifdef TPU_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign timed_out = !done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state != WAIT_DONE) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus the next pin values, so every pin leaves a flop.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = LOAD;
      LOAD:      if (idx == IW'(7)) state_nx = WAIT_DONE;
      WAIT_DONE: if (done) state_nx = READ;
                 else if (timed_out) state_nx = IDLE;
      READ:      if (!done) state_nx = IDLE;
                 else if (idx == IW'(RESULT_BYTES - 1)) state_nx = FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    src     = (state == IDLE) ? {mat_b, mat_a} : ops;
    lidx    = (state == IDLE) ? 3'd0 : 3'(idx + 1'b1);
    tr_nx   = (state == IDLE) ? transpose_cfg : tr_q;
    relu_nx = (state == IDLE) ? relu_cfg : relu_q;
    go      = (state_nx != IDLE);
    ui_nx   = (state_nx == LOAD) ? src[8*lidx +: 8] : 8'h00;
    uio_nx  = {5'b0, relu_nx & go, tr_nx & go, state_nx == LOAD};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      ops          <= '0;
      tr_q         <= 1'b0;
      relu_q       <= 1'b0;
      shadow       <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      tpu_ui_in    <= '0;
      tpu_uio_in   <= '0;
    end else begin
      result_valid <= 1'b0;
      busy         <= (state_nx != IDLE);
      tpu_ui_in    <= ui_nx;
      tpu_uio_in   <= uio_nx;
      case (state)
        IDLE: begin
          if (start) begin
            ops    <= {mat_b, mat_a};
            tr_q   <= transpose_cfg;
            relu_q <= relu_cfg;
            error  <= 1'b0;
            idx    <= '0;
          end
        end
        LOAD: idx <= idx + 1'b1;
        WAIT_DONE: begin
          if (done) begin
            shadow[7:0] <= tpu_uo_out;
            idx         <= IW'(1);
          end else if (timed_out) begin
            error <= 1'b1;
          end
        end
        READ: begin
          if (done) begin
            shadow[8*idx +: 8] <= tpu_uo_out;
            idx                <= idx + 1'b1;
          end
        end
        FINISH: begin
          result       <= shadow;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// tb/tb_tpu_host_driver.sv - self-checking bench for tpu_host_driver with a behavioural 2x2 TPU
module tb_tpu_host_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mat_a, mat_b;
  logic        transpose_cfg, relu_cfg;
  logic        busy;
  logic [63:0] result;
  logic        result_valid;
  logic        error;
  logic [7:0]  tpu_ui_in, tpu_uio_in;
  logic [7:0]  tpu_uo_out, tpu_uio_out;

  int tests = 0;
  int fails = 0;

  tpu_host_driver #(
    .RESULT_BYTES(8)
`ifdef TPU_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_a(mat_a), .mat_b(mat_b),
    .transpose_cfg(transpose_cfg), .relu_cfg(relu_cfg), .busy(busy), .result(result),
    .result_valid(result_valid), .error(error), .tpu_ui_in(tpu_ui_in), .tpu_uio_in(tpu_uio_in),
    .tpu_uo_out(tpu_uo_out), .tpu_uio_out(tpu_uio_out)
  );

  always #5 clk = ~clk;

  // Behavioural TPU: latches 8 load bytes, waits model_delay cycles, then streams C low byte first.
  int          model_delay = 0;
  int          model_glitch = 0;
  int          m_phase, m_cnt, m_wait, m_sent;
  logic [7:0]  m_mem [8];
  logic [7:0]  m_out [8];
  int          mc [4];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_wait = 0; m_sent = 0;
      tpu_uio_out = 8'h00; tpu_uo_out = 8'h00;
    end else begin
      if (m_phase != 0 && tpu_uio_in[0]) begin
        m_phase = 0; m_cnt = 0; tpu_uio_out = 8'h55; tpu_uo_out = 8'h00;
      end
      case (m_phase)
        0: if (tpu_uio_in[0] && m_cnt < 8) begin
             m_mem[m_cnt] = tpu_ui_in;
             m_cnt++;
             if (m_cnt == 8) begin
               mc[0] = $signed(m_mem[0]) * $signed(m_mem[4]) + $signed(m_mem[1]) * $signed(m_mem[6]);
               mc[1] = $signed(m_mem[0]) * $signed(m_mem[5]) + $signed(m_mem[1]) * $signed(m_mem[7]);
               mc[2] = $signed(m_mem[2]) * $signed(m_mem[4]) + $signed(m_mem[3]) * $signed(m_mem[6]);
               mc[3] = $signed(m_mem[2]) * $signed(m_mem[5]) + $signed(m_mem[3]) * $signed(m_mem[7]);
               for (int k = 0; k < 4; k++) begin
                 m_out[2*k]   = mc[k][7:0];
                 m_out[2*k+1] = mc[k][15:8];
               end
               m_phase = 1;
               m_wait  = model_delay;
             end
           end
        1: if (model_delay >= 0) begin
             if (m_wait <= 0) begin
               tpu_uio_out = 8'hD5; tpu_uo_out = m_out[0]; m_sent = 1; m_phase = 2;
             end else m_wait--;
           end
        2: if (m_sent >= 8 || (model_glitch > 0 && m_sent >= model_glitch)) begin
             tpu_uio_out = 8'h55; tpu_uo_out = 8'h00; m_phase = 0; m_cnt = 0;
           end else begin
             tpu_uo_out = m_out[m_sent]; m_sent++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // mode 0: completes with result; 1: returns to IDLE without result; 2: stays busy for the whole bound
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic tr, input logic rl,
                         input int delay, input int glitch, input int mode, input logic [63:0] exp_res,
                         input int exp_cyc, input logic exp_err, input bit poke, input int bound);
    int          n_load = 0;
    int          n_valid = 0;
    int          cyc_evt = 0;
    logic [63:0] ldv = '0;
    logic [7:0]  uio_ld = '0;
    logic [7:0]  uio_wt = '0;
    bit          fin = 0;
    model_delay  = delay;
    model_glitch = glitch;
    mat_a = a; mat_b = b; transpose_cfg = tr; relu_cfg = rl; start = 1'b1;
    for (int cyc = 1; cyc <= bound && !fin; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 3 || cyc == 12 || cyc == 17);
      if (cyc == 1) begin
        chk("busy_rise", busy, 1'b1);
        chk("error_clear_on_start", error, 1'b0);
      end
      if (tpu_uio_in[0]) begin
        ldv = {tpu_ui_in, ldv[63:8]};
        n_load++;
        uio_ld = tpu_uio_in;
      end else if (busy) uio_wt = tpu_uio_in;
      if (result_valid) n_valid++;
      if (result_valid || (mode != 2 && !busy)) begin
        fin = 1;
        cyc_evt = cyc;
      end
    end
    start = 1'b0;
    if (mode == 2) begin
      chk("hang_busy", busy, 1'b1);
      chk("hang_no_valid", n_valid, 0);
      chk("hang_error", error, 1'b0);
    end else begin
      chk("load_cycles", n_load, 8);
      chk("load_bytes", ldv, {b, a});
      chk("uio_during_load", uio_ld, {5'b0, rl, tr, 1'b1});
      chk("result", result, exp_res);
      chk("valid_pulses", n_valid, (mode == 0) ? 1 : 0);
      chk("event_cycle", cyc_evt, exp_cyc);
      chk("busy_end", busy, 1'b0);
      chk("uio_idle", tpu_uio_in, 8'h00);
      chk("error_end", error, exp_err);
      if (mode == 0) chk("uio_during_wait_read", uio_wt, {5'b0, rl, tr, 1'b0});
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        tr;
    logic        rl;
    int          delay;
    logic [63:0] res;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{32'h04030201, 32'h08070605, 1'b0, 1'b0, 0, 64'h0032_002B_0016_0013};
    vecs[1] = '{32'h010002FF, 32'h0605FC03, 1'b1, 1'b0, 3, 64'h0006_0005_0010_0007};
    vecs[2] = '{32'h80808080, 32'h80808080, 1'b0, 1'b1, 0, 64'h8000_8000_8000_8000};
    vecs[3] = '{32'h7F7F7F7F, 32'h01FF01FF, 1'b1, 1'b1, 1, 64'h00FE_FF02_00FE_FF02};

    rst_n = 1'b0; start = 1'b0; mat_a = '0; mat_b = '0; transpose_cfg = 1'b0; relu_cfg = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 64'h0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_ui", tpu_ui_in, 8'h00);
    chk("rst_uio", tpu_uio_in, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each start lands in the IDLE cycle that shows result_valid.
    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].tr, vecs[i].rl, vecs[i].delay, 0, 0,
              vecs[i].res, 18 + vecs[i].delay, 1'b0, 1'b0, 60);

    // Starts during LOAD, READ and FINISH must be dropped, not queued.
    run_txn(vecs[1].a, vecs[1].b, vecs[1].tr, vecs[1].rl, 0, 0, 0, vecs[1].res, 18, 1'b0, 1'b1, 60);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_queued_start", busy, 1'b0);
    end

    // done high for 3 cycles only: abort, result keeps the previous value.
    run_txn(vecs[0].a, vecs[0].b, 1'b1, 1'b1, 0, 3, 1, vecs[1].res, 13, 1'b0, 1'b0, 60);
    @(negedge clk);

`ifdef TPU_HOST_TIMEOUT_EN
    run_txn(vecs[2].a, vecs[2].b, 1'b0, 1'b0, -1, 0, 1, vecs[1].res, 25, 1'b1, 1'b0, 60);
    @(negedge clk);
    chk("error_sticky", error, 1'b1);
    run_txn(vecs[3].a, vecs[3].b, vecs[3].tr, vecs[3].rl, 0, 0, 0, vecs[3].res, 18, 1'b0, 1'b0, 60);
`else
    run_txn(vecs[2].a, vecs[2].b, 1'b0, 1'b0, -1, 0, 2, vecs[1].res, 0, 1'b0, 1'b0, 40);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hang_recover_busy", busy, 1'b0);
`endif

    // Reset while LOAD is presenting byte 4.
    model_delay = 0; model_glitch = 0;
    mat_a = vecs[0].a; mat_b = vecs[0].b; transpose_cfg = 1'b1; relu_cfg = 1'b1; start = 1'b1;
    for (int i = 0; i < 20 && tpu_ui_in != 8'h05; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("reach_byte4", tpu_ui_in, 8'h05);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ui", tpu_ui_in, 8'h00);
    chk("async_rst_uio", tpu_uio_in, 8'h00);
    chk("async_rst_result", result, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(vecs[2].a, vecs[2].b, vecs[2].tr, vecs[2].rl, 0, 0, 0, vecs[2].res, 18, 1'b0, 1'b0, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
